// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package pptrees_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    localparam int MIN_WIDTH       = 2;
    localparam int MIN_STAGE_EVERY = 1;

    function automatic int prefix_levels(input int width);
        int l = 0;
        while ((1 << l) < width) l++;
        return l;
    endfunction

    function automatic int pipe_latency(input int width, input int stage_every);
        return 1 + (prefix_levels(width) - 1) / stage_every;
    endfunction

    function automatic bit cfg_ok(input int width, input int stage_every);
        return (width >= MIN_WIDTH) && (stage_every >= MIN_STAGE_EVERY);
    endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// Kogge-Stone (g,p) combine: g is an ao21, p is an and2.
module prefix_gp_cell
    import pptrees_adder_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = hi.p & lo.p;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with bubble-collapsing valid/ready stages.
module pipelined_prefix_adder
    import pptrees_adder_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int STAGE_EVERY = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = prefix_levels(WIDTH);
    localparam int NSTG   = pipe_latency(WIDTH, STAGE_EVERY);
    localparam bit CFG_OK = cfg_ok(WIDTH, STAGE_EVERY);

    if (!CFG_OK) begin : g_bad_cfg
        $error("pipelined_prefix_adder: WIDTH must be >= 2 and STAGE_EVERY >= 1");
    end

    logic [NSTG-1:0] vld_pipe;
    logic [NSTG-1:0] up_vld;
    logic [NSTG-1:0] ld;
    logic [NSTG:0]   rdy;

    // A stage may load whenever it is empty or its successor is draining.
    always_comb begin
        rdy       = '0;
        rdy[NSTG] = out_ready;
        for (int s = NSTG - 1; s >= 0; s--) rdy[s] = ~vld_pipe[s] | rdy[s+1];
        up_vld[0] = in_valid;
        for (int s = 1; s < NSTG; s++) up_vld[s] = vld_pipe[s-1];
        ld = rdy[NSTG-1:0] & up_vld;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            for (int s = 0; s < NSTG; s++) if (rdy[s]) vld_pipe[s] <= up_vld[s];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[NSTG-1];

    // Position j carries bit j-1; position 0 is the virtual carry-in bit.
    // The top operand bit stays out of the tree and is folded in after it.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        gp_t [WIDTH-1:0]  nd;
        logic [WIDTH-1:0] p0;
        logic             gt;
        logic [TAG_W-1:0] tg;

        if (k == 0) begin : g_pre
            logic [WIDTH-1:0] bx;
            assign bx    = in_b ^ {WIDTH{in_sub}};
            assign p0    = in_a ^ bx;
            assign gt    = in_a[WIDTH-1] & bx[WIDTH-1];
            assign tg    = in_tag;
            assign nd[0] = '{g: in_cin ^ in_sub, p: 1'b0};
            for (genvar j = 1; j < WIDTH; j++) begin : g_bit
                assign nd[j] = '{g: in_a[j-1] & bx[j-1], p: p0[j-1]};
            end
        end else begin : g_level
            localparam int D = 1 << (k - 1);
            gp_t [WIDTH-1:0] cmb;

            for (genvar j = 0; j < WIDTH; j++) begin : g_pos
                if (j >= D) begin : g_cell
                    prefix_gp_cell u_cell (
                        .hi (g_lvl[k-1].nd[j]),
                        .lo (g_lvl[k-1].nd[j-D]),
                        .o  (cmb[j])
                    );
                end else begin : g_pass
                    assign cmb[j] = g_lvl[k-1].nd[j];
                end
            end

            if ((k % STAGE_EVERY == 0) && (k < LEVELS)) begin : g_reg
                localparam int S = k / STAGE_EVERY - 1;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        nd <= '0;
                        p0 <= '0;
                        gt <= 1'b0;
                        tg <= '0;
                    end else if (ld[S]) begin
                        nd <= cmb;
                        p0 <= g_lvl[k-1].p0;
                        gt <= g_lvl[k-1].gt;
                        tg <= g_lvl[k-1].tg;
                    end
                end
            end else begin : g_wire
                assign nd = cmb;
                assign p0 = g_lvl[k-1].p0;
                assign gt = g_lvl[k-1].gt;
                assign tg = g_lvl[k-1].tg;
            end
        end
    end

    logic [WIDTH:0] carry;
    logic           unused_p;

    always_comb begin
        carry    = '0;
        unused_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i] = g_lvl[LEVELS].nd[i].g;
            unused_p = unused_p ^ g_lvl[LEVELS].nd[i].p;
        end
        carry[WIDTH] = g_lvl[LEVELS].gt | (g_lvl[LEVELS].p0[WIDTH-1] & carry[WIDTH-1]);
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            tag_q  <= '0;
        end else if (ld[NSTG-1]) begin
            sum_q  <= g_lvl[LEVELS].p0 ^ carry[WIDTH-1:0];
            cout_q <= carry[WIDTH];
            ovf_q  <= carry[WIDTH] ^ carry[WIDTH-1];
            tag_q  <= g_lvl[LEVELS].tg;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;
    assign out_tag  = tag_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed and scoreboarded checks of the pipelined prefix adder (8-bit and 32-bit builds).
module tb_pipelined_prefix_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv8, ir8, cin8, sub8, ov8, or8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic [3:0] tag8, otag8;

    logic        iv32, ir32, cin32, sub32, ov32, or32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;
    logic [3:0]  tag32, otag32;

    pipelined_prefix_adder #(.WIDTH(8), .STAGE_EVERY(2), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .in_cin(cin8), .in_sub(sub8), .in_tag(tag8), .out_valid(ov8), .out_ready(or8),
        .out_sum(sum8), .out_cout(cout8), .out_ovf(ovf8), .out_tag(otag8)
    );

    pipelined_prefix_adder #(.WIDTH(32), .STAGE_EVERY(1), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32),
        .in_cin(cin32), .in_sub(sub32), .in_tag(tag32), .out_valid(ov32), .out_ready(or32),
        .out_sum(sum32), .out_cout(cout32), .out_ovf(ovf32), .out_tag(otag32)
    );

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic [3:0]  t;
    } exp_t;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            sub8 = 1'($urandom); tag8 = 4'($urandom); or8 = 1'($urandom);
            iv32 = 1'($urandom); a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
            sub32 = 1'($urandom); tag32 = 4'($urandom); or32 = 1'($urandom);
            step();
            n_vec++;
            if (ov8 !== 1'b0 || sum8 !== 8'h00 || otag8 !== 4'h0 || cout8 !== 1'b0 ||
                ovf8 !== 1'b0 || ov32 !== 1'b0) begin
                n_miss++;
                $display("FAIL reset_state[%0d]: got v=%b sum=%h tag=%h c=%b o=%b v32=%b want all 0",
                         i, ov8, sum8, otag8, cout8, ovf8, ov32);
            end
        end
        rst = 1'b0; iv8 = 1'b0; iv32 = 1'b0; or8 = 1'b1; or32 = 1'b1;
        step();
        n_vec++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || ir32 !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b in_ready32=%b want 1 0 1",
                     ir8, ov8, ir32);
        end
    endtask

    task automatic test_add();
        logic [7:0] va [2] = '{8'hFF, 8'h7F};
        logic [7:0] vs [2] = '{8'h00, 8'h80};
        logic       vc [2] = '{1'b1, 1'b0};
        logic       vo [2] = '{1'b0, 1'b1};
        logic [3:0] vt [2] = '{4'd5, 4'd6};
        for (int i = 0; i < 2; i++) begin
            a8 = va[i]; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; tag8 = vt[i]; iv8 = 1'b1; or8 = 1'b1;
            #1;
            n_vec++;
            if (ir8 !== 1'b1) begin
                n_miss++; $display("FAIL add_in_ready[%0d]: got %b want 1", i, ir8);
            end
            step();
            iv8 = 1'b0;
            #1;
            n_vec++;
            if (ov8 !== 1'b0) begin
                n_miss++; $display("FAIL add_early_valid[%0d]: got %b want 0", i, ov8);
            end
            step();
            n_vec++;
            if (ov8 !== 1'b1 || sum8 !== vs[i] || cout8 !== vc[i] || ovf8 !== vo[i] || otag8 !== vt[i]) begin
                n_miss++;
                $display("FAIL add_result[%0d]: got v=%b sum=%h c=%b o=%b tag=%0d want 1 %h %b %b %0d",
                         i, ov8, sum8, cout8, ovf8, otag8, vs[i], vc[i], vo[i], vt[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0] va [4] = '{8'h05, 8'h05, 8'h80, 8'h07};
        logic [7:0] vb [4] = '{8'h07, 8'h07, 8'h01, 8'h05};
        logic       vi [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] vs [4] = '{8'hFE, 8'hFD, 8'h7F, 8'h02};
        logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       vo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            a8 = va[i]; b8 = vb[i]; cin8 = vi[i]; sub8 = 1'b1; tag8 = 4'(i + 8); iv8 = 1'b1; or8 = 1'b1;
            step();
            iv8 = 1'b0;
            step();
            n_vec++;
            if (ov8 !== 1'b1 || sum8 !== vs[i] || cout8 !== vc[i] || ovf8 !== vo[i] || otag8 !== 4'(i + 8)) begin
                n_miss++;
                $display("FAIL sub_result[%0d]: got v=%b sum=%h c=%b o=%b tag=%0d want 1 %h %b %b %0d",
                         i, ov8, sum8, cout8, ovf8, otag8, vs[i], vc[i], vo[i], i + 8);
            end
        end
        sub8 = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_s [4] = '{8'h25, 8'h35, 8'h45, 8'h55};
        int   idx;
        logic acc;
        or8 = 1'b0; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        for (idx = 0; idx < 3; idx++) begin
            a8 = {idx[3:0], 4'h3}; tag8 = idx[3:0];
            #1;
            n_vec++;
            if (ir8 !== (idx < 2)) begin
                n_miss++; $display("FAIL bp_in_ready[%0d]: got %b want %b", idx, ir8, idx < 2);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            n_vec++;
            if (ov8 !== 1'b1 || otag8 !== 4'd0 || sum8 !== 8'h25 || ir8 !== 1'b0) begin
                n_miss++;
                $display("FAIL bp_stall[%0d]: got v=%b tag=%0d sum=%h rdy=%b want 1 0 25 0",
                         k, ov8, otag8, sum8, ir8);
            end
            step();
        end
        idx = 2; or8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++;
            if (ov8 !== 1'b1 || otag8 !== k[3:0] || sum8 !== exp_s[k]) begin
                n_miss++;
                $display("FAIL bp_drain[%0d]: got v=%b tag=%0d sum=%h want 1 %0d %h",
                         k, ov8, otag8, sum8, k, exp_s[k]);
            end
            acc = iv8 & ir8;
            step();
            if (acc) idx++;
            if (idx < 4) begin
                a8 = {idx[3:0], 4'h3}; tag8 = idx[3:0];
            end else begin
                iv8 = 1'b0;
            end
        end
        #1;
        n_vec++;
        if (ov8 !== 1'b0) begin
            n_miss++; $display("FAIL bp_extra: got out_valid=%b want 0", ov8);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        or8 = 1'b0; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; tag8 = 4'd9; iv8 = 1'b1;
        step();
        tag8 = 4'd10;
        step();
        iv8 = 1'b0;
        #1;
        n_vec++;
        if (ov8 !== 1'b1) begin
            n_miss++; $display("FAIL midrst_pre: got out_valid=%b want 1", ov8);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (ov8 !== 1'b0 || sum8 !== 8'h00 || otag8 !== 4'h0) begin
            n_miss++;
            $display("FAIL midrst_async: got v=%b sum=%h tag=%0d want 0 00 0", ov8, sum8, otag8);
        end
        rst = 1'b0; or8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
                n_miss++;
                $display("FAIL midrst_after[%0d]: got v=%b rdy=%b want 0 1", i, ov8, ir8);
            end
        end
    endtask

    task automatic test_latency();
        int cnt;
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0; tag32 = 4'd3;
        iv32 = 1'b1; or32 = 1'b1;
        step();
        iv32 = 1'b0;
        cnt = 1;
        while (ov32 !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        n_vec++;
        if (cnt != 5 || sum32 !== 32'h0 || cout32 !== 1'b1 || ovf32 !== 1'b0 || otag32 !== 4'd3) begin
            n_miss++;
            $display("FAIL lat32: got cycles=%0d sum=%h c=%b o=%b tag=%0d want 5 00000000 1 0 3",
                     cnt, sum32, cout32, ovf32, otag32);
        end
        step();
    endtask

    task automatic test_random();
        exp_t        q [$];
        exp_t        e;
        int          beats = 0;
        int          cyc;
        logic        stall = 1'b0;
        logic        acc, cons;
        logic [31:0] ls, bp;
        logic [3:0]  lt;
        logic [32:0] full;
        for (cyc = 0; cyc < 20000 && !(beats >= 1500 && q.size() == 0); cyc++) begin
            iv32  = ($urandom_range(0, 3) != 0) && (beats < 1500);
            a32   = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
            b32   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cin32 = 1'($urandom); sub32 = 1'($urandom); tag32 = beats[3:0];
            or32  = ($urandom_range(0, 3) != 0);
            #1;
            if (stall) begin
                n_vec++;
                if (ov32 !== 1'b1 || sum32 !== ls || otag32 !== lt) begin
                    n_miss++;
                    $display("FAIL rand_stable[%0d]: got v=%b sum=%h tag=%0d want 1 %h %0d",
                             cyc, ov32, sum32, otag32, ls, lt);
                end
            end
            acc  = iv32 & ir32;
            cons = ov32 & or32;
            if (cons) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_miss++; $display("FAIL rand_spurious[%0d]: got sum=%h with empty queue", cyc, sum32);
                end else begin
                    e = q.pop_front();
                    if (sum32 !== e.s || cout32 !== e.c || ovf32 !== e.o || otag32 !== e.t) begin
                        n_miss++;
                        $display("FAIL rand_result[%0d]: got %h %b %b %0d want %h %b %b %0d",
                                 cyc, sum32, cout32, ovf32, otag32, e.s, e.c, e.o, e.t);
                    end
                end
            end
            if (acc) begin
                bp   = sub32 ? ~b32 : b32;
                full = {1'b0, a32} + {1'b0, bp} + 33'(cin32 ^ sub32);
                e.s  = full[31:0];
                e.c  = full[32];
                e.o  = (a32[31] == bp[31]) && (full[31] != a32[31]);
                e.t  = tag32;
                q.push_back(e);
                beats++;
            end
            stall = ov32 & ~or32;
            ls    = sum32;
            lt    = otag32;
            step();
        end
        n_vec++;
        if (beats != 1500 || q.size() != 0) begin
            n_miss++;
            $display("FAIL rand_complete: got beats=%0d pending=%0d want 1500 0", beats, q.size());
        end
        iv32 = 1'b0;
    endtask

    initial begin
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; tag8 = '0; or8 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; tag32 = '0; or32 = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_midflight();
        test_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready handshakes on input and output.
- Generalises the team's single-cell combinational primitives into a width-configurable datapath.
- Pipeline registers sit at a configurable prefix-level interval.
- Sits between operand-issue logic and result consumers; intended as a characterisation vehicle for synthesis experiments.

Parameters:
- WIDTH, 32: operand width in bits; must be at least 2; need not be a power of two.
- STAGE_EVERY, 2: insert a pipeline register after every STAGE_EVERY prefix levels; must be at least 1.
- TAG_W, 4: sideband tag width; the tag passes through unchanged, in order.

Ports:
- clk  in  1  single clock; all flops rise-edge triggered.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (borrow-in when subtracting).
- in_sub  in  1  1 = A - B, 0 = A + B.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  sum or difference.
- out_cout  out  1  carry-out of bit WIDTH-1.
- out_ovf  out  1  signed overflow.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Derived constants:
  - LEVELS = ceil(log2(WIDTH)).
  - NSTG = 1 + floor((LEVELS-1)/STAGE_EVERY); NSTG is the latency in cycles.
  - Example: WIDTH=32, STAGE_EVERY=2 gives LEVELS=5, NSTG=3. WIDTH=8 gives NSTG=2.
- Pre-process (combinational, before stage 0):
  - b' = in_b XOR {WIDTH{in_sub}}; c0 = in_cin XOR in_sub.
  - g_i = a_i & b'_i; p_i = a_i ^ b'_i.
  - c0 is folded in as the generate of a virtual bit -1.
- Prefix levels:
  - Level k combines the (g,p) pair at i with the pair at i-2^(k-1) when that index is at least -1.
  - Combine: g = g_hi | (p_hi & g_lo); p = p_hi & p_lo.
- Registers:
  - Stage registers follow levels STAGE_EVERY, 2*STAGE_EVERY, ... below LEVELS.
  - The final stage register sits after the post-process.
  - Post-process: sum_i = p0_i ^ c_i; cout = c_WIDTH; ovf = c_WIDTH ^ c_(WIDTH-1).
  - The original per-bit propagate p0 and the tag travel with every stage.
- Handshake (bubble-collapsing):
  - Each stage s holds a valid bit v_s.
  - ready_s = !v_s | ready_(s+1); ready_NSTG = out_ready.
  - in_ready = ready_0.
  - Stage s loads when ready_s. v_s takes the upstream valid (in_valid for stage 0).
  - Data regs load only when ready_s and upstream valid; otherwise they hold.
- Output: out_valid = v_(NSTG-1). Output data is the last stage register. A result is consumed when out_valid & out_ready.
- Ordering: results leave in acceptance order. No drop and no duplication under any in_valid/out_ready pattern.
- Throughput and latency:
  - Throughput is 1 beat/cycle while out_ready=1.
  - Latency is exactly NSTG cycles from acceptance to out_valid when unstalled.
- Stall:
  - With out_ready=0, up to NSTG beats are buffered.
  - in_ready stays 1 until every stage is valid.
  - Output data must stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept and consume on a full pipeline is allowed: in_ready=1 when out_ready=1.
- Reset:
  - rst asserts all v_s=0 asynchronously, mid-operation included.
  - out_sum, out_cout, out_ovf and out_tag all reset to 0; out_valid=0.
  - in_ready=1 in the first cycle after deassert.
  - In-flight beats are discarded; nothing is emitted after release.
- Width rules: all arithmetic is modulo 2^WIDTH. There is no X propagation from unused prefix positions; indices below -1 pass through unchanged.

Decomposition:
- Package pptrees_adder_pkg holds:
  - functions prefix_levels(WIDTH) and pipe_latency(WIDTH, STAGE_EVERY);
  - a packed gp_t struct {g, p};
  - a localparam check that WIDTH is at least 2 and STAGE_EVERY is at least 1.
- Sub-module prefix_gp_cell: the (g,p) combine operator. Its g path maps onto the team's ao21 cell and its p path onto and2. It is instantiated per bit per level via generate.

Test Plan (WIDTH=8, STAGE_EVERY=2, NSTG=2 unless stated):
- Reset: hold rst high 3 cycles with random inputs -> out_valid=0, out_sum=0x00, out_tag=0; in_ready=1 one cycle after release.
- Add: A=0xFF, B=0x01, cin=0, sub=0, tag=5 -> out_valid exactly 2 cycles later, sum=0x00, cout=1, ovf=0, tag=5. A=0x7F, B=0x01 -> sum=0x80, cout=0, ovf=1.
- Subtract: A=0x05, B=0x07, sub=1, cin=0 -> sum=0xFE, cout=0, ovf=0. Same with cin=1 -> sum=0xFD.
- Backpressure: out_ready=0, stream tags 0..3 back to back -> in_ready falls after 2 beats are accepted. On release, tags 0,1,2,3 emerge in order with correct sums, one per cycle; output is stable while stalled.
- Reset mid-flight: 2 beats in flight, pulse rst for less than one cycle between edges -> out_valid drops immediately, and no result appears after release.
- Random: WIDTH=32, STAGE_EVERY=1 and 3, 10k beats with random in_valid/out_ready -> every result matches the reference model (A ± B + cin mod 2^32, cout, ovf, tag) in order; latency = pipe_latency when unstalled.
